// File: rtl/fpga_input_debounce.sv
// Input conditioning for the board wrappers. Raw buttons and switches pass through a
// synchronizer and a tick-sampled debouncer, which produces clean levels and one-cycle edge pulses.
module fpga_input_debounce #(
  parameter int NBTN           = 4,
  parameter int NSW            = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TICK_DIV       = 100000,
  parameter int STABLE_SAMPLES = 8
) (
  input  logic            CLK_100MHZ,
  input  logic            RST,
  input  logic [NBTN-1:0] BTN_IN,
  input  logic [NSW-1:0]  SW_IN,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NSW-1:0]  sw_level,
  output logic [NSW-1:0]  sw_change,
  output logic            tick
);

  localparam int N     = NBTN + NSW;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  // Buttons occupy the low bits and switches the high bits of every per-input vector.
  logic [SYNC_STAGES-1:0][N-1:0] sync_ff;
  logic [N-1:0]                  sync_q;

  logic [DIV_W-1:0] div_cnt;

  logic [N-1:0][CNT_W-1:0] cnt, cnt_d;
  logic [N-1:0]            level, level_d;
  logic [N-1:0]            accept, accept_d;

  // NOTE: synchronizer flops are reset too, so no stale pre-reset sample can count toward qualification.
  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], {SW_IN, BTN_IN}};
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // NOTE: every signal gets a default before the loop, so a bit with no tick holds and no latch is inferred.
  always_comb begin
    cnt_d    = cnt;
    level_d  = level;
    accept_d = '0;
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (sync_q[i] == level[i]) begin
          cnt_d[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          level_d[i]  = sync_q[i];
          cnt_d[i]    = '0;
          accept_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      cnt    <= '0;
      level  <= '0;
      accept <= '0;
    end else begin
      cnt    <= cnt_d;
      level  <= level_d;
      accept <= accept_d;
    end
  end

  // The accept strobe and the level are both registers, so the direction decode stays glitch-free.
  assign btn_level   = level[NBTN-1:0];
  assign btn_press   = accept[NBTN-1:0] & level[NBTN-1:0];
  assign btn_release = accept[NBTN-1:0] & ~level[NBTN-1:0];
  assign sw_level    = level[N-1:NBTN];
  assign sw_change   = accept[N-1:NBTN];

endmodule

// File: tb/tb_fpga_input_debounce.sv
// Bench for fpga_input_debounce. A sliding-window reference model is compared against the outputs
// every cycle, and directed scenarios pin latency, bounce, glitch, multi-bit and reset behaviour.
module tb_fpga_input_debounce;

  localparam int NBTN = 4;
  localparam int NSW  = 16;
  localparam int SYNC = 2;
  localparam int DIV  = 4;
  localparam int S    = 3;
  localparam int N    = NBTN + NSW;

  logic            clk = 1'b0;
  logic            rst;
  logic [NBTN-1:0] btn_in;
  logic [NSW-1:0]  sw_in;
  logic [NBTN-1:0] btn_level, btn_press, btn_release;
  logic [NSW-1:0]  sw_level, sw_change;
  logic            tick;
  logic [N-1:0]    lvl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpga_input_debounce #(
    .NBTN(NBTN), .NSW(NSW), .SYNC_STAGES(SYNC), .TICK_DIV(DIV), .STABLE_SAMPLES(S)
  ) dut (
    .CLK_100MHZ (clk),
    .RST        (rst),
    .BTN_IN     (btn_in),
    .SW_IN      (sw_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sw_level   (sw_level),
    .sw_change  (sw_change),
    .tick       (tick)
  );

  assign lvl = {sw_level, btn_level};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a level flips when the last S tick samples of the delayed input all differ from it.
  logic [N-1:0] m_pipe [SYNC];
  logic [N-1:0] m_win [$];
  logic [N-1:0] m_level, m_acc, m_sq;
  logic         m_tick;
  logic         m_all;
  int           m_edges;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_level = '0;
      m_acc   = '0;
      m_tick  = 1'b0;
      m_edges = 0;
      m_win.delete();
      for (int i = 0; i < SYNC; i++) m_pipe[i] = '0;
    end else begin
      m_sq  = m_pipe[SYNC-1];
      m_acc = '0;
      if (m_tick) begin
        m_win.push_back(m_sq);
        if (m_win.size() > S) void'(m_win.pop_front());
        if (m_win.size() == S) begin
          for (int b = 0; b < N; b++) begin
            m_all = 1'b1;
            foreach (m_win[j]) if (m_win[j][b] == m_level[b]) m_all = 1'b0;
            m_acc[b] = m_all;
          end
        end
        m_level = m_level ^ m_acc;
      end
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = {sw_in, btn_in};
      m_edges++;
      m_tick = (m_edges % DIV == 0);
    end
  end

  initial forever begin
    @(negedge clk);
    check("cycle",
          {tick, sw_change, sw_level, btn_release, btn_press, btn_level},
          {m_tick, m_acc[N-1:NBTN], m_level[N-1:NBTN],
           m_acc[NBTN-1:0] & ~m_level[NBTN-1:0],
           m_acc[NBTN-1:0] & m_level[NBTN-1:0], m_level[NBTN-1:0]});
  end

  task automatic wait_tick();
    int n;
    n = 0;
    while (!tick && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("tick_seen", tick, 1'b1);
  endtask

  initial begin
    int n, ticks, first_tick, bad_phase, pulses, presses, releases, falls, first_press;
    logic prev;
    rst    = 1'b1;
    btn_in = '0;
    sw_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tick, sw_change, sw_level, btn_release, btn_press, btn_level}, 64'h0);
    rst = 1'b0;

    // Tick cadence and idle silence
    ticks = 0; first_tick = -1; bad_phase = 0; pulses = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (tick) begin
        ticks++;
        if (first_tick < 0) first_tick = k;
        if (k % DIV != 0) bad_phase++;
      end
      if (|{btn_press, btn_release, sw_change}) pulses++;
    end
    check("tick_count", ticks, 25);
    check("tick_first", first_tick, 4);
    check("tick_phase", bad_phase, 0);
    check("idle_pulses", pulses, 0);

    // Clean press and release on button 2
    btn_in[2] = 1'b1;
    n = 0;
    while (n < 40 && lvl[2] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("press_latency", (n >= 11 && n <= 15), 1'b1);
    check("press_coincident", btn_press, 4'b0100);
    check("press_level_only", lvl, 20'h4);
    pulses = 0;
    repeat (40 - n) begin
      @(negedge clk);
      if (|{btn_press, btn_release, sw_change}) pulses++;
    end
    check("press_single", pulses, 0);
    btn_in[2] = 1'b0;
    n = 0;
    while (n < 40 && lvl[2] !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    check("release_latency", (n >= 11 && n <= 15), 1'b1);
    check("release_coincident", btn_release, 4'b0100);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (|{btn_press, btn_release, sw_change}) pulses++;
    end
    check("release_single", pulses, 0);

    // Bounce on button 0 then a steady hold
    pulses = 0;
    for (int seg = 0; seg < 4; seg++) begin
      btn_in[0] = (seg % 2 == 0);
      repeat (3) begin
        @(negedge clk);
        if (btn_press[0] || btn_release[0]) pulses++;
      end
    end
    check("bounce_quiet", pulses, 0);
    btn_in[0] = 1'b1;
    presses = 0; releases = 0; falls = 0; prev = btn_level[0];
    repeat (40) begin
      @(negedge clk);
      if (btn_press[0]) presses++;
      if (btn_release[0]) releases++;
      if (prev && !btn_level[0]) falls++;
      prev = btn_level[0];
    end
    check("bounce_one_press", presses, 1);
    check("bounce_no_release", releases + falls, 0);
    check("bounce_level", btn_level, 4'b0001);
    btn_in[0] = 1'b0;
    repeat (30) @(negedge clk);

    // Short glitch between ticks on switch 7
    wait_tick();
    sw_in[7] = 1'b1;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (sw_level[7] || (|sw_change)) pulses++;
    end
    sw_in[7] = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (sw_level[7] || (|sw_change)) pulses++;
    end
    check("glitch_ignored", pulses, 0);

    // Simultaneous multi-bit switch change
    sw_in = 16'hA5C3;
    n = 0;
    while (n < 20 && sw_level == '0) begin
      @(negedge clk);
      n++;
    end
    check("multi_level", sw_level, 16'hA5C3);
    check("multi_change", sw_change, 16'hA5C3);
    @(negedge clk);
    check("multi_change_width", sw_change, 16'h0);
    repeat (10) @(negedge clk);
    sw_in = 16'h0000;
    n = 0;
    while (n < 20 && sw_level != '0) begin
      @(negedge clk);
      n++;
    end
    check("multi_back_level", sw_level, 16'h0);
    check("multi_back_change", sw_change, 16'hA5C3);
    repeat (10) @(negedge clk);

    // Reset one cycle before the accepting tick of button 1
    sw_in = 16'h00FF;
    repeat (20) @(negedge clk);
    check("pre_reset_sw", sw_level, 16'h00FF);
    wait_tick();
    btn_in[1] = 1'b1;
    repeat (12) @(negedge clk);
    check("btn1_not_yet", btn_level[1], 1'b0);
    #1 rst = 1'b1;
    #1 check("async_clear", {tick, sw_change, sw_level, btn_release, btn_press, btn_level}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    presses = 0; first_press = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (btn_press[1]) begin
        presses++;
        if (first_press < 0) first_press = k;
      end
    end
    check("requal_once", presses, 1);
    check("requal_min", (first_press >= 11), 1'b1);
    check("requal_sw", sw_level, 16'h00FF);

    // Randomized traffic checked against the model every cycle
    for (int step = 0; step < 300; step++) begin
      if ($urandom_range(0, 2) == 0) btn_in = NBTN'($urandom);
      sw_in = sw_in ^ NSW'($urandom & $urandom);
      if (step == 150) begin
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
      else repeat ($urandom_range(12, 30)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_input_debounce.md
Name: fpga_input_debounce

Overview:
Input-side conditioning block for the FPGA wrappers. It takes raw asynchronous board inputs (push buttons and slide switches), synchronizes them to CLK_100MHZ, and debounces them. It delivers clean levels plus one-cycle press/release/change pulses to downstream logic such as ALU operand entry and opcode select. It is the input counterpart to the multiplexed seven-segment display path.

Parameters:
NBTN, 4, number of push-button inputs
NSW, 16, number of slide-switch inputs
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (>=2)
TICK_DIV, 100000, CLK_100MHZ cycles per debounce sample tick (1 ms); >=1
STABLE_SAMPLES, 8, consecutive differing ticks required to accept a new level; >=1

Ports:
CLK_100MHZ  input   1     system clock
RST         input   1     asynchronous active-high reset
BTN_IN      input   NBTN  raw button pins, asynchronous
SW_IN       input   NSW   raw switch pins, asynchronous
btn_level   output  NBTN  debounced button level
btn_press   output  NBTN  one-cycle pulse on debounced 0->1
btn_release output  NBTN  one-cycle pulse on debounced 1->0
sw_level    output  NSW   debounced switch level
sw_change   output  NSW   one-cycle pulse on any debounced switch transition
tick        output  1     debug: sample tick strobe

Behaviour:
- Reset is asynchronous on RST high and clears everything: synchronizer flops, prescaler, per-input counters, all levels and pulses. btn_level=0, sw_level=0, btn_press/btn_release/sw_change=0, tick=0.
- Synchronizer: each input bit passes through SYNC_STAGES flops. Only the last stage (sync_q) is used downstream.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered. It is high for exactly one cycle each time the count equals TICK_DIV-1.
  - With TICK_DIV=1, tick is high every cycle after reset.
- Per-input debounce. Counter cnt has width clog2(STABLE_SAMPLES+1). All NBTN+NSW inputs use identical logic and the shared tick.
  - No tick: cnt and level hold.
  - Tick with sync_q == level: cnt is cleared to 0. A bounce restarts qualification.
  - Tick with sync_q != level and cnt+1 < STABLE_SAMPLES: cnt increments.
  - Tick with sync_q != level and cnt+1 == STABLE_SAMPLES: level is set to sync_q and cnt is cleared.
  - STABLE_SAMPLES=1 means the level is accepted on the first differing tick.
- Pulses:
  - Registered and asserted in the same clock edge that updates level. The pulse is high in the first cycle level shows its new value, and for exactly one cycle.
  - btn_press fires on a new level of 1; btn_release fires on a new level of 0.
  - sw_change fires on either direction.
  - Pulses can only occur on tick+1 cycles.
  - Several bits may pulse in the same cycle.
- Latency:
  - An input that changes and then stays stable is reflected in level after at most SYNC_STAGES + STABLE_SAMPLES*TICK_DIV + 1 cycles.
  - It is reflected after at least SYNC_STAGES + (STABLE_SAMPLES-1)*TICK_DIV + 1 cycles.
- Glitch rejection: any input pulse shorter than TICK_DIV cycles that straddles no tick has no effect. A bounce that is still present at a tick resets qualification.
- Reset mid-qualification: counters drop to 0 and levels to 0. After release, a held-high input must fully requalify, and it produces a press pulse when accepted.
- Inputs that are high at reset release: level starts at 0, qualifies normally, then pulses press/change once.
- No handshake: outputs are free-running. Consumers must sample pulses every cycle.

Test Plan:
All scenarios use TICK_DIV=4, STABLE_SAMPLES=3, SYNC_STAGES=2, NBTN=4, NSW=16.

1. Reset and tick cadence: hold RST for 3 cycles, release, all inputs 0. Required: all outputs 0; tick high on cycles 4, 8, 12, … after release (period 4, width 1); no pulses over 100 cycles.
2. Clean press/release: BTN_IN[2] goes 0->1 and is held for 40 cycles, then 1->0. Required:
   - btn_level[2] rises within 11..15 cycles of the input edge.
   - btn_press[2] is high for exactly 1 cycle, coincident with the rise.
   - The release gives a btn_release[2] single pulse with the same latency window.
   - Other bits stay 0.
3. Bounce rejection: BTN_IN[0] toggles 1,0,1,0 with 3-cycle widths, then holds 1. Required:
   - No pulse during bouncing.
   - Exactly one btn_press[0] after the final hold qualifies (3 consecutive differing ticks).
   - btn_level[0] never goes 1->0->1.
4. Short glitch: SW_IN[7] is high for 2 cycles between ticks. Required: sw_level[7] stays 0 and sw_change is 0 throughout.
5. Simultaneous multi-input: SW_IN changes from 16'h0000 to 16'hA5C3 in one cycle. Required:
   - sw_level becomes 16'hA5C3 in one cycle.
   - sw_change equals 16'hA5C3 for exactly one cycle.
   - Returning SW_IN to 16'h0000 gives sw_change=16'hA5C3 again.
6. Reset mid-qualification: BTN_IN[1] is held at 1 and RST is asserted one cycle before the accepting tick. Required:
   - Outputs clear immediately (asynchronously).
   - After release, btn_press[1] fires exactly once, no earlier than 11 cycles later.
